// File: rtl/sha256_msg_sched.sv
// Purpose : SHA-256 message scheduler; expands one 512-bit block into W0..W(ROUNDS-1).
// Latency : first word valid the cycle after block acceptance, then one word per transfer.
// Backpr. : wt_ready=0 freezes the window and outputs; blk_ready is low for the whole block.
//
// Ports:
//   clk, rst                     rising-edge clock, synchronous active-high reset
//   blk_valid/blk_ready/blk_data 512-bit block handshake (W0 = blk_data[511:480])
//   wt_o/wt_valid/wt_ready       schedule word stream towards the compression core
//   round_idx_o                  index t of wt_o
//   wt_last                      marks the final word of the block
//   busy                         high while a block is being streamed
module sha256_msg_sched #(
  parameter int unsigned ROUNDS = 64
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         blk_valid,
  output logic         blk_ready,
  input  logic [511:0] blk_data,
  output logic [31:0]  wt_o,
  output logic         wt_valid,
  input  logic         wt_ready,
  output logic [5:0]   round_idx_o,
  output logic         wt_last,
  output logic         busy
);

  typedef enum logic {IDLE, RUN} state_t;

  localparam logic [5:0] LAST_IDX = 6'(ROUNDS - 1);

  state_t      state_q, state_d;
  logic [31:0] win_q [16];
  logic [5:0]  count_q;
  logic        accept;
  logic        xfer;
  logic        last_xfer;
  logic [31:0] w_new;

  function automatic logic [31:0] sig0(input logic [31:0] x);
    return {x[6:0], x[31:7]} ^ {x[17:0], x[31:18]} ^ (x >> 3);
  endfunction

  function automatic logic [31:0] sig1(input logic [31:0] x);
    return {x[16:0], x[31:17]} ^ {x[18:0], x[31:19]} ^ (x >> 10);
  endfunction

  // Window slot 0 holds W[t]; slots 1, 9, 14 are W[t+1], W[t+9], W[t+14],
  // which is exactly the recurrence for W[t+16].
  assign w_new = sig1(win_q[14]) + win_q[9] + sig0(win_q[1]) + win_q[0];

  always_comb begin
    state_d   = state_q;
    blk_ready = 1'b0;
    wt_valid  = 1'b0;
    busy      = 1'b0;
    accept    = 1'b0;
    xfer      = 1'b0;
    last_xfer = 1'b0;
    case (state_q)
      IDLE: begin
        blk_ready = 1'b1;
        accept    = blk_valid;
        if (accept) state_d = RUN;
      end
      RUN: begin
        wt_valid  = 1'b1;
        busy      = 1'b1;
        xfer      = wt_ready;
        last_xfer = wt_ready && (count_q == LAST_IDX);
        if (last_xfer) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Word output is forced to zero outside RUN so stale window data never leaks.
  assign wt_o        = (state_q == RUN) ? win_q[0] : 32'h0;
  assign round_idx_o = count_q;
  assign wt_last     = wt_valid && (count_q == LAST_IDX);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      count_q <= '0;
      for (int i = 0; i < 16; i++) win_q[i] <= '0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        for (int i = 0; i < 16; i++) win_q[i] <= blk_data[511 - 32*i -: 32];
        count_q <= '0;
      end else if (xfer) begin
        for (int i = 0; i < 15; i++) win_q[i] <= win_q[i+1];
        win_q[15] <= w_new;
        // Index returns to 0 on the final word so IDLE always shows round 0.
        count_q   <= last_xfer ? 6'd0 : count_q + 6'd1;
      end
    end
  end

endmodule
